instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the RV32IMA pipeline: owns the PC, issues single-outstanding requests to instruction memory, and drives the IF/ID register (`instruction`, `pc_id`) consumed by decode. It honours decode's stall (active-low hold) and flush (redirect plus bubble) semantics. Optionally it replaces unsupported opcodes with a bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `stall` in 1: active-low hold; 0 = IF/ID holds, 1 = IF/ID may advance
- `flush` in 1: active-high redirect and IF/ID clear
- `flush_pc` in 32: redirect target, sampled when `flush`=1; bits [1:0] forced to 0
- `imem_req` out 1: request strobe, one cycle per fetch; memory always accepts
- `imem_addr` out 32: word-aligned fetch address, valid with `imem_req`
- `imem_rvalid` in 1: response valid, ≥1 cycle after request
- `imem_rdata` in 32: response data, valid with `imem_rvalid`
- `instruction` out 32: IF/ID instruction; 0 = bubble
- `pc_id` out 32: PC of `instruction`
- `illegal_instr` out 1: IF/ID flag, fetched opcode was filtered

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD; internal `pc`, 32-bit `skid`, `discard` flag.
- IDLE: reset state; go to REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=`pc`; go to WAIT.
- WAIT: wait for `imem_rvalid`. On response:
  - `discard`=1: drop the response, clear `discard`, go to REQ.
  - else `stall`=1: load IF/ID, `pc_id`<=`pc`, `pc`<=`pc`+4 (mod 2^32), go to REQ.
  - else `stall`=0: capture into `skid`, go to HOLD.
- HOLD: when `stall`=1, move `skid` to IF/ID, `pc`<=`pc`+4, go to REQ.
- IF/ID advance with no fetched word available (`stall`=1, not delivering): load `instruction`=0, `illegal_instr`=0, `pc_id` unchanged.
- `stall`=0 and `flush`=0: `instruction`, `pc_id`, `illegal_instr` hold exactly.
- `flush`=1 has priority over `stall` and over any delivery. Next cycle `instruction`=0 and `illegal_instr`=0. `pc`<=`flush_pc`.
  - In WAIT without `imem_rvalid`, or in REQ: set `discard`.
  - In WAIT with `imem_rvalid` that same cycle: drop the response and go to REQ.
  - In HOLD: drop `skid` and go to REQ.
  - In IDLE: state unchanged.
- `imem_rvalid` outside WAIT is ignored.
- Legal opcode set: 0000011, 1100011, 0110011, 0010011, 0010111, 1100111, 1101111, 0100011, 0110111, 0000000.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instruction`=0, `pc_id`=0, `illegal_instr`=0, `pc`=`RESET_PC`, state IDLE, `discard`=0.
- Reset asserted mid-operation clears everything immediately. A response arriving after reset release, while in IDLE, is ignored.
- First fetch after reset release (1-cycle memory): cycle 0 IDLE, cycle 1 `imem_req`, cycle 2 `imem_rvalid`, cycle 3 `instruction` valid.
- Steady-state throughput is one instruction per 2 cycles with 1-cycle memory.
- Flush-to-new-instruction latency is 3 cycles with 1-cycle memory, or 4 if a discard is pending.
- All outputs are registered, except `imem_req`/`imem_addr`, which decode directly from state/`pc` flops.

## Configuration
- `FETCH_OPCODE_FILTER_EN` defined:
  - A fetched word whose opcode is outside the legal set enters IF/ID as `instruction`=0 with `illegal_instr`=1.
  - `pc_id` still takes that word's PC.
- Not defined: words pass unchanged and `illegal_instr` is tied 0.

## Test plan
- Reset release, memory returns 32'h0000_0013 one cycle after each request, `stall`=1 → `imem_addr` 0,4,8 on cycles 1,3,5; `instruction`=32'h13 with `pc_id`=0 on cycle 3.
- `stall`=0 for 4 cycles while a response arrives in WAIT → `instruction`/`pc_id` frozen. Word held in HOLD; appears one cycle after `stall`=1 with correct PC. No extra `imem_req`.
- `flush`=1, `flush_pc`=32'h100, one cycle before `imem_rvalid` → next cycle `instruction`=0. Stale response dropped; next `imem_addr`=32'h100.
- `flush`=1 and `stall`=0 in the same cycle → `instruction`=0 next cycle; `pc`=`flush_pc`.
- With `FETCH_OPCODE_FILTER_EN`, memory returns 32'h0000_002F (AMO opcode) → `instruction`=0, `illegal_instr`=1. Without the macro → `instruction`=32'h2F, `illegal_instr`=0.
- `reset` asserted while in WAIT, `imem_rvalid` arriving in the first cycle after release → response ignored. All outputs at reset values; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage_if
//
// Instruction-memory bus between the fetch stage and instruction memory.
// Only one request is ever outstanding and the memory always accepts.
//
//   imem_req    : request strobe, high for exactly one cycle per fetch
//   imem_addr   : word-aligned fetch address, valid while imem_req is high
//   imem_rvalid : response valid, at least one cycle after the request
//   imem_rdata  : response data, valid while imem_rvalid is high
//
// Modports:
//   master : fetch stage side (drives req/addr, receives rvalid/rdata)
//   slave  : memory side
// -----------------------------------------------------------------------------
interface instruction_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage of the RV32IMA pipeline. Owns the PC, issues single-outstanding
// requests to instruction memory and drives the IF/ID register consumed by
// decode. Decode may hold IF/ID (stall low) or redirect the PC and clear IF/ID
// (flush high); flush always wins.
//
// Parameters:
//   RESET_PC      : PC loaded on reset, must be word aligned
//
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous reset, active low
//   stall         : 0 = IF/ID holds, 1 = IF/ID may advance
//   flush         : redirect to flush_pc and clear IF/ID
//   flush_pc      : redirect target, low two bits ignored
//   imem          : instruction-memory bus (master side)
//   instruction   : IF/ID instruction, 0 is a bubble
//   pc_id         : PC of instruction
//   illegal_instr : IF/ID flag, the fetched opcode was filtered out
//
// Build option:
//   FETCH_OPCODE_FILTER_EN : when defined, words with an opcode outside the
//   supported set enter IF/ID as a bubble with illegal_instr set. When not
//   defined, fetched words pass unchanged and illegal_instr stays 0.
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    instruction_fetch_stage_if.master  imem,
    output logic [31:0]                instruction,
    output logic [31:0]                pc_id,
    output logic                       illegal_instr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] skid_q;
    logic        discard_q;
    logic [31:0] instr_q;
    logic [31:0] pc_id_q;
    logic        illegal_q;

    logic [31:0] fetch_word;
    logic        deliver;
    logic [31:0] load_instr;
    logic        load_illegal;

    // The word headed for IF/ID comes from the skid buffer once decode has
    // stalled a response; otherwise straight from the memory bus.
    assign fetch_word = (state_q == HOLD) ? skid_q : imem.imem_rdata;

    // A fetched word moves into IF/ID this cycle (flush overrides this).
    assign deliver = stall &&
                     (((state_q == WAIT) && imem.imem_rvalid && !discard_q) ||
                      (state_q == HOLD));

`ifdef FETCH_OPCODE_FILTER_EN
    function automatic logic opcode_legal(input logic [6:0] opcode);
        case (opcode)
            7'b0000011, 7'b1100011, 7'b0110011, 7'b0010011, 7'b0010111,
            7'b1100111, 7'b1101111, 7'b0100011, 7'b0110111, 7'b0000000:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    always_comb begin
        load_illegal = !opcode_legal(fetch_word[6:0]);
        load_instr   = load_illegal ? 32'h0 : fetch_word;
    end
`else
    assign load_instr   = fetch_word;
    assign load_illegal = 1'b0;
`endif

    // The request strobe and address decode straight from the state and PC
    // flops so memory sees the request in the same cycle the FSM enters REQ.
    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;

    assign instruction   = instr_q;
    assign pc_id         = pc_id_q;
    assign illegal_instr = illegal_q;

    // NOTE: every register here is assigned with <= so all flops update from
    // the same pre-edge values; a blocking = would let later statements see
    // already-updated state and change the behaviour with statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            skid_q    <= 32'h0;
            discard_q <= 1'b0;
            instr_q   <= 32'h0;
            pc_id_q   <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            // IF/ID register: flush clears, a delivery loads, an advance with
            // nothing to deliver inserts a bubble, otherwise hold exactly.
            if (flush) begin
                instr_q   <= 32'h0;
                illegal_q <= 1'b0;
            end else if (deliver) begin
                instr_q   <= load_instr;
                illegal_q <= load_illegal;
                pc_id_q   <= pc_q;
            end else if (stall) begin
                instr_q   <= 32'h0;
                illegal_q <= 1'b0;
            end

            // PC and fetch FSM
            if (flush) begin
                pc_q <= flush_pc & ~32'h3;
                case (state_q)
                    IDLE: state_q <= IDLE;
                    REQ: begin
                        // The request just issued is stale; drop its response.
                        discard_q <= 1'b1;
                        state_q   <= WAIT;
                    end
                    WAIT: begin
                        if (imem.imem_rvalid) begin
                            // The stale response is here now: drop it in place.
                            discard_q <= 1'b0;
                            state_q   <= REQ;
                        end else begin
                            discard_q <= 1'b1;
                        end
                    end
                    HOLD:    state_q <= REQ;
                    default: state_q <= IDLE;
                endcase
            end else begin
                case (state_q)
                    IDLE: state_q <= REQ;
                    REQ:  state_q <= WAIT;
                    WAIT: begin
                        if (imem.imem_rvalid) begin
                            if (discard_q) begin
                                discard_q <= 1'b0;
                                state_q   <= REQ;
                            end else if (stall) begin
                                pc_q    <= pc_q + 32'd4;
                                state_q <= REQ;
                            end else begin
                                // Decode is holding: park the word until released.
                                skid_q  <= imem.imem_rdata;
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (stall) begin
                            pc_q    <= pc_q + 32'd4;
                            state_q <= REQ;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Self-checking bench for instruction_fetch_stage. A behavioural memory answers
// each request after a programmable latency. Every observed request address
// is compared against the expected fetch address and queued as in flight;
// every new IF/ID value is popped against that queue. A flush or reset empties
// the queue. Directed timing checks cover reset, stall hold, flush, the opcode
// filter and reset during an outstanding fetch; a short random phase follows.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] instruction;
    logic [31:0] pc_id;
    logic        illegal_instr;

    instruction_fetch_stage_if imem ();

    instruction_fetch_stage #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .imem         (imem),
        .instruction  (instruction),
        .pc_id        (pc_id),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_deliv  = 0;
    int          n_req    = 0;
    int          mem_lat  = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'h0;
    logic [31:0] exp_next = RESET_PC;
    logic [31:0] inflight[$];
    logic [64:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Memory contents: one AMO word at 0x200, otherwise an ADDI-type word
    // carrying its own address so every fetch is distinguishable.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0200) return 32'h0000_002F;
        return {addr[24:0], 7'h13};
    endfunction

    function automatic void exp_word(input logic [31:0] addr,
                                     output logic [31:0] ins, output logic ill);
        logic [31:0] w;
        w = mem_word(addr);
`ifdef FETCH_OPCODE_FILTER_EN
        if (w[6:0] == 7'h2F) begin
            ins = 32'h0;
            ill = 1'b1;
        end else begin
            ins = w;
            ill = 1'b0;
        end
`else
        ins = w;
        ill = 1'b0;
`endif
    endfunction

    // Sample/drive point: 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        exp_next = target & ~32'h3;
        inflight.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, instruction, 32'h0);
        check({tag, "_pc_id"}, pc_id, 32'h0);
        check({tag, "_illegal"}, {31'h0, illegal_instr}, 32'h0);
        check({tag, "_req"}, {31'h0, imem.imem_req}, 32'h0);
        check({tag, "_addr"}, imem.imem_addr, RESET_PC);
    endtask

    // Memory model: answers a request mem_lat cycles later for one cycle.
    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem.imem_rvalid = 1'b0;
            if (pend_cnt == 1) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = pend_data;
            end
            if (pend_cnt > 0) pend_cnt--;
            if (imem.imem_req) begin
                pend_cnt  = mem_lat;
                pend_data = mem_word(imem.imem_addr);
            end
        end
    end

    // Scoreboard monitor: 1 time unit after each rising edge.
    initial begin
        logic [64:0] cur;
        logic [31:0] e_addr;
        logic [31:0] e_ins;
        logic        e_ill;
        forever begin
            @(posedge clk);
            #1;
            cur = {illegal_instr, instruction, pc_id};
            if (cur != prev_out && !(instruction == 32'h0 && !illegal_instr)) begin
                e_addr = (inflight.size() > 0) ? inflight.pop_front() : 32'hFFFF_FFFF;
                exp_word(e_addr, e_ins, e_ill);
                check("sb_pc_id", pc_id, e_addr);
                check("sb_instr", instruction, e_ins);
                check("sb_illegal", {31'h0, illegal_instr}, {31'h0, e_ill});
                n_deliv++;
            end
            prev_out = cur;
            if (imem.imem_req) begin
                check("sb_imem_addr", imem.imem_addr, exp_next);
                inflight.push_back(exp_next);
                exp_next = exp_next + 32'd4;
                n_req++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_ins;
        logic        e_ill;
        int          req_snap;

        // Reset state
        repeat (2) tick();
        check_reset_outputs("rst");
        reset = 1'b1;

        // First fetches with 1-cycle memory and stall=1
        tick();  // cycle 1
        check("c1_req", {31'h0, imem.imem_req}, 32'h1);
        check("c1_addr", imem.imem_addr, 32'h0);
        tick();  // cycle 2
        check("c2_req", {31'h0, imem.imem_req}, 32'h0);
        tick();  // cycle 3
        check("c3_instr", instruction, 32'h0000_0013);
        check("c3_pc_id", pc_id, 32'h0);
        check("c3_addr", imem.imem_addr, 32'h4);
        tick();  // cycle 4
        check("c4_bubble", instruction, 32'h0);
        tick();  // cycle 5
        check("c5_req", {31'h0, imem.imem_req}, 32'h1);
        check("c5_addr", imem.imem_addr, 32'h8);
        check("c5_instr", instruction, mem_word(32'h4));

        // Stall for 4 cycles while the next response lands in WAIT
        stall    = 1'b0;
        req_snap = n_req;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_instr", instruction, mem_word(32'h4));
            check("hold_pc_id", pc_id, 32'h4);
        end
        check("hold_no_req", n_req - req_snap, 32'h0);
        stall = 1'b1;
        tick();  // cycle 10: skid word released
        check("skid_instr", instruction, mem_word(32'h8));
        check("skid_pc_id", pc_id, 32'h8);
        check("skid_next_addr", imem.imem_addr, 32'hC);

        // Flush one cycle before a slow response arrives
        mem_lat = 3;
        tick();
        tick();  // cycle 12
        do_flush(32'h0000_0100);
        tick();  // cycle 13
        flush   = 1'b0;
        mem_lat = 1;
        check("fl_bubble", instruction, 32'h0);
        check("fl_illegal", {31'h0, illegal_instr}, 32'h0);
        tick();  // cycle 14
        check("fl_addr", imem.imem_addr, 32'h100);
        tick();
        tick();  // cycle 16
        check("fl_instr", instruction, mem_word(32'h100));
        check("fl_pc_id", pc_id, 32'h100);

        // Flush together with stall=0, redirect onto the AMO word
        stall = 1'b0;
        do_flush(32'h0000_0200);
        tick();  // cycle 17
        flush = 1'b0;
        stall = 1'b1;
        check("fs_bubble", instruction, 32'h0);
        check("fs_illegal", {31'h0, illegal_instr}, 32'h0);
        tick();  // cycle 18
        check("fs_addr", imem.imem_addr, 32'h200);
        tick();
        tick();  // cycle 20
        exp_word(32'h200, e_ins, e_ill);
        check("amo_instr", instruction, e_ins);
        check("amo_illegal", {31'h0, illegal_instr}, {31'h0, e_ill});
        check("amo_pc_id", pc_id, 32'h200);

        // Reset while in WAIT; the late response lands right after release
        mem_lat = 2;
        tick();  // cycle 21: DUT in WAIT
        reset    = 1'b0;
        exp_next = RESET_PC;
        inflight.delete();
        #1;
        check_reset_outputs("midrst");
        mem_lat = 1;
        tick();  // cycle 22
        reset = 1'b1;
        tick();  // cycle 23
        check("rr_req", {31'h0, imem.imem_req}, 32'h1);
        check("rr_addr", imem.imem_addr, RESET_PC);
        check("rr_instr", instruction, 32'h0);
        tick();  // cycle 24
        check("rr_wait", {31'h0, imem.imem_req}, 32'h0);
        tick();  // cycle 25
        check("rr_first_instr", instruction, mem_word(RESET_PC));
        check("rr_first_pc", pc_id, RESET_PC);

        // Random stalls, latencies and flushes, including a wrap past 2^32
        for (int i = 0; i < 60; i++) begin
            stall   = ($urandom_range(0, 3) != 0);
            mem_lat = $urandom_range(1, 3);
            if (i == 0) do_flush(32'hFFFF_FFFE);
            else if ($urandom_range(0, 9) == 0) do_flush($urandom);
            else flush = 1'b0;
            tick();
        end
        flush   = 1'b0;
        stall   = 1'b1;
        mem_lat = 1;
        repeat (8) tick();
        check("sb_drained", {31'h0, inflight.size() <= 1}, 32'h1);
        check("deliveries", {31'h0, n_deliv >= 10}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
